inv_cipher: RTL and testbench
=============================

# inv_cipher

Iterative AES-128 inverse cipher (FIPS-197 §5.3) that turns one 16-byte ciphertext block into plaintext. It is the decrypt-side counterpart of the cipher datapath and computes one decryption round per clock. Round keys come from an external key-schedule store through a combinational index/data port. The block sits between the ciphertext source and the plaintext sink, with valid/ready handshakes on both sides.

## Interface
- No parameters. AES-128 only: Nr = 10, Nb = 4.
- clk  in  1  sole clock; all state changes on the rising edge
- rst  in  1  asynchronous, active-high reset
- ct  in  [7:0][0:3][0:3]  ciphertext state; ct[r][c] is FIPS-197 input byte r+4c
- in_valid  in  1  ct is valid
- in_ready  out  1  block accepts ct this cycle
- rk_idx  out  4  round-key index requested, 0..10
- rk  in  [7:0][0:3][0:3]  round key for rk_idx, same cycle, same byte layout as ct
- pt  out  [7:0][0:3][0:3]  plaintext state, same byte layout
- out_valid  out  1  pt is valid
- out_ready  in  1  sink takes pt this cycle

## Operation
- State machine states:
  - IDLE: in_ready = 1, rk_idx = 10. On in_valid: state ← ct ⊕ rk (AddRoundKey with w[40..43]), round ← 9, go to ROUND.
  - ROUND, round = 9..1: state ← InvMixColumns(InvSubBytes(InvShiftRows(state)) ⊕ rk), with rk_idx = round. Then round ← round − 1.
  - ROUND, round = 0: state ← InvSubBytes(InvShiftRows(state)) ⊕ rk, with rk_idx = 0 and no InvMixColumns. Go to DONE.
  - DONE: out_valid = 1, pt = state, rk_idx = 0. On out_ready, go to IDLE.
- InvShiftRows: row r rotates right by r, so new[r][c] = old[r][(c − r) mod 4].
- InvSubBytes: 256-entry inverse S-box as a combinational table over all 16 bytes.
- InvMixColumns: per column, multiply by {0e,0b,0d,09} in GF(2^8) modulo x^8+x^4+x^3+x+1. Build it from xtime chains. All byte arithmetic is 8-bit XOR with no carries.
- AddRoundKey is a bytewise XOR. rk is sampled in the same cycle rk_idx is driven.
- pt is a direct register output equal to the state register, so it is stable throughout DONE.
- in_ready is high only in IDLE. There is no overlap between output and the next input.
- ct is ignored outside IDLE, and so is in_valid. out_ready is ignored outside DONE.

## Timing
- Reset values: state = all 0x00, FSM = IDLE, round = 0.
- Outputs at reset: in_ready = 1, out_valid = 0, pt = all 0x00, rk_idx = 10.
- Latency:
  - Input handshake at edge E0. ROUND runs for 10 cycles, edges E1..E10.
  - out_valid rises after E10.
  - The result is first available 10 cycles after acceptance.
- Throughput: one block every 12 cycles when out_ready is held high, counted as 1 accept + 10 rounds + 1 DONE cycle.
- Backpressure: DONE holds pt and out_valid indefinitely until out_ready is seen. On the out_ready edge, out_valid = 0 and in_ready = 1 in the next cycle.
- rk_idx is a function of FSM/round only, never of rk, so no combinational loop can form.
- Reset asserted mid-operation aborts the block immediately:
  - all registers return to reset values asynchronously;
  - a partial result is never presented;
  - the next accepted block decrypts correctly.

## Test plan
- Vector 1, FIPS-197 App. C.1.
  - Stimulus: key 000102030405060708090a0b0c0d0e0f, ct 69c4e0d86a7b0430d8cdb78070b4c55a.
  - Response: pt 00112233445566778899aabbccddeeff, and out_valid rises exactly 10 cycles after acceptance.
  - Check the rk_idx sequence 10, 9, …, 1, 0, 0.
- Vector 2, FIPS-197 App. B.
  - Stimulus: key 2b7e151628aed2a6abf7158809cf4f3c, ct 3925841d02dc09fbdc118597196a0b32.
  - Response: pt 3243f6a8885a308d313198a2e0370734.
  - Also check state after round 9 against the App. B intermediate values.
- Backpressure.
  - Stimulus: hold out_ready = 0 for 20 cycles in DONE, with in_valid = 1 and a different ct driven throughout.
  - Response: pt stays constant, in_ready = 0, and the second block is accepted only in the cycle after out_ready.
- Back-to-back.
  - Stimulus: 8 random blocks with in_valid and out_ready both tied high.
  - Response: every pt matches the reference model, and the accept spacing is exactly 12 cycles.
- Reset mid-round.
  - Stimulus: assert rst during round 5.
  - Response: out_valid = 0, pt = 0, in_ready = 1, and rk_idx = 10 immediately. A following App. C.1 block then yields the correct plaintext.
- Idle stability.
  - Stimulus: in_valid = 0 for 50 cycles while ct toggles.
  - Response: state is unchanged and out_valid stays 0.

Source files
------------

// File: rtl/inv_cipher_if.sv
// Ciphertext-in / plaintext-out handshake bundle for inv_cipher,
// including the combinational round-key lookup port.
interface inv_cipher_if;
  logic [0:3][0:3][7:0] ct;
  logic                 in_valid;
  logic                 in_ready;
  logic [3:0]           rk_idx;
  logic [0:3][0:3][7:0] rk;
  logic [0:3][0:3][7:0] pt;
  logic                 out_valid;
  logic                 out_ready;

  modport master (
    output ct, in_valid, rk, out_ready,
    input  in_ready, rk_idx, pt, out_valid
  );

  modport slave (
    input  ct, in_valid, rk, out_ready,
    output in_ready, rk_idx, pt, out_valid
  );
endinterface

// File: rtl/inv_cipher.sv
// Iterative AES-128 inverse cipher, one decryption round per clock.
// Round keys are fetched through the rk_idx/rk lookup port.
module inv_cipher (
  input  logic     clk,
  input  logic     rst,
  inv_cipher_if.slave bus
);
  typedef enum logic [1:0] {IDLE, ROUND, DONE} fsm_t;
  typedef logic [0:3][0:3][7:0] st_t;

  localparam logic [0:255][7:0] INV_SBOX = {
    128'h52096ad53036a538bf40a39e81f3d7fb,
    128'h7ce339829b2fff87348e4344c4dee9cb,
    128'h547b9432a6c2233dee4c950b42fac34e,
    128'h082ea16628d924b2765ba2496d8bd125,
    128'h72f8f66486689816d4a45ccc5d65b692,
    128'h6c704850fdedb9da5e154657a78d9d84,
    128'h90d8ab008cbcd30af7e45805b8b34506,
    128'hd02c1e8fca3f0f02c1afbd0301138a6b,
    128'h3a9111414f67dcea97f2cfcef0b4e673,
    128'h96ac7422e7ad3585e2f937e81c75df6e,
    128'h47f11a711d29c5896fb7620eaa18be1b,
    128'hfc563e4bc6d279209adbc0fe78cd5af4,
    128'h1fdda8338807c731b11210592780ec5f,
    128'h60517fa919b54a0d2de57a9f93c99cef,
    128'ha0e03b4dae2af5b0c8ebbb3c83539961,
    128'h172b047eba77d626e169146355210c7d
  };

  fsm_t       st, nst;
  logic [3:0] round;
  st_t        s, sh, sb, ark, mc;

  function automatic logic [7:0] xt(
    input logic [7:0] b
  );
    return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
  endfunction

  // Packed as {x0e, x0b, x0d, x09}.
  function automatic logic [31:0] mults(
    input logic [7:0] a
  );
    logic [7:0] x2, x4, x8;
    x2 = xt(a);
    x4 = xt(x2);
    x8 = xt(x4);
    return {x8 ^ x4 ^ x2, x8 ^ x2 ^ a,
            x8 ^ x4 ^ a, x8 ^ a};
  endfunction

  // Row r of the circulant uses coefficient order e,b,d,9
  // starting at column index r.
  function automatic st_t inv_mix(input st_t a);
    st_t        o;
    logic [31:0] m [4];
    logic [1:0]  off;
    o = '0;
    for (int c = 0; c < 4; c++) begin
      for (int k = 0; k < 4; k++)
        m[k] = mults(a[k][c]);
      for (int r = 0; r < 4; r++)
        for (int k = 0; k < 4; k++) begin
          off = 2'(k - r);
          o[r][c] ^= m[k][8*(3-off) +: 8];
        end
    end
    return o;
  endfunction

  always_comb begin
    sh = '0;
    sb = '0;
    for (int r = 0; r < 4; r++)
      for (int c = 0; c < 4; c++) begin
        sh[r][c] = s[r][2'(c - r)];
        sb[r][c] = INV_SBOX[sh[r][c]];
      end
    ark = sb ^ bus.rk;
    mc  = inv_mix(ark);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) st <= IDLE;
    else     st <= nst;
  end

  always_comb begin
    nst = st;
    unique case (st)
      IDLE:  if (bus.in_valid) nst = ROUND;
      ROUND: if (round == 4'd0) nst = DONE;
      DONE:  if (bus.out_ready) nst = IDLE;
      default: nst = IDLE;
    endcase
  end

  always_comb begin
    bus.in_ready  = 1'b0;
    bus.out_valid = 1'b0;
    bus.rk_idx    = 4'd0;
    unique case (st)
      IDLE: begin
        bus.in_ready = 1'b1;
        bus.rk_idx   = 4'd10;
      end
      ROUND:   bus.rk_idx    = round;
      DONE:    bus.out_valid = 1'b1;
      default: bus.rk_idx    = 4'd0;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s     <= '0;
      round <= 4'd0;
    end else begin
      unique case (st)
        IDLE:
          if (bus.in_valid) begin
            s     <= bus.ct ^ bus.rk;
            round <= 4'd9;
          end
        ROUND: begin
          s <= (round == 4'd0) ? ark : mc;
          if (round != 4'd0) round <= round - 4'd1;
        end
        default: ;
      endcase
    end
  end

  assign bus.pt = s;
endmodule

// File: tb/tb_inv_cipher.sv
// Randomized self-checking bench for inv_cipher against an
// arithmetic AES-128 decryption model.
module tb_inv_cipher;
  typedef logic [0:3][0:3][7:0] st_t;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  inv_cipher_if bus ();
  inv_cipher dut (.clk(clk), .rst(rst), .bus(bus));

  st_t rks [0:10];
  int  sbox  [256];
  int  isbox [256];
  int  checks   = 0;
  int  failures = 0;

  always_comb
    bus.rk = (bus.rk_idx <= 4'd10) ? rks[bus.rk_idx] : '0;

  function automatic logic [7:0] gmul(
    input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p;
    p = '0;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) p ^= a;
      a = {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
    end
    return p;
  endfunction

  function automatic logic [7:0] rotl(
    input logic [7:0] b, input int n);
    return 8'((b << n) | (b >> (8 - n)));
  endfunction

  // S-box from GF(2^8) inverse plus the affine map.
  task automatic build_sbox();
    logic [7:0] inv, s;
    for (int x = 0; x < 256; x++) begin
      inv = '0;
      if (x != 0)
        for (int y = 1; y < 256; y++)
          if (gmul(8'(x), 8'(y)) == 8'h01) inv = 8'(y);
      s = inv ^ rotl(inv, 1) ^ rotl(inv, 2)
          ^ rotl(inv, 3) ^ rotl(inv, 4) ^ 8'h63;
      sbox[x]  = int'(s);
      isbox[s] = x;
    end
  endtask

  function automatic st_t from_hex(input logic [127:0] h);
    st_t s;
    for (int k = 0; k < 16; k++)
      s[k % 4][k / 4] = h[127 - 8*k -: 8];
    return s;
  endfunction

  function automatic st_t rand_st();
    logic [127:0] t;
    t = {$urandom, $urandom, $urandom, $urandom};
    return st_t'(t);
  endfunction

  task automatic set_key(input logic [127:0] k);
    logic [31:0] w [44];
    logic [31:0] t;
    logic [7:0]  rc;
    rc = 8'h01;
    for (int i = 0; i < 4; i++) w[i] = k[127 - 32*i -: 32];
    for (int i = 4; i < 44; i++) begin
      t = w[i-1];
      if (i % 4 == 0) begin
        t = {t[23:0], t[31:24]};
        t = {8'(sbox[t[31:24]]), 8'(sbox[t[23:16]]),
             8'(sbox[t[15:8]]), 8'(sbox[t[7:0]])};
        t[31:24] ^= rc;
        rc = gmul(rc, 8'h02);
      end
      w[i] = w[i-4] ^ t;
    end
    for (int j = 0; j <= 10; j++)
      for (int c = 0; c < 4; c++)
        for (int r = 0; r < 4; r++)
          rks[j][r][c] = w[4*j + c][31 - 8*r -: 8];
  endtask

  // Standard inverse cipher, stopped after nr rounds.
  function automatic st_t model(input st_t ct, input int nr);
    st_t s, t, n;
    logic [7:0] cf [4];
    int rd;
    cf = '{8'h0e, 8'h0b, 8'h0d, 8'h09};
    s = ct ^ rks[10];
    for (int i = 1; i <= nr; i++) begin
      rd = 10 - i;
      for (int r = 0; r < 4; r++)
        for (int c = 0; c < 4; c++)
          t[r][c] = 8'(isbox[s[r][(c - r + 4) % 4]]);
      t ^= rks[rd];
      if (rd != 0) begin
        n = '0;
        for (int r = 0; r < 4; r++)
          for (int c = 0; c < 4; c++)
            for (int k = 0; k < 4; k++)
              n[r][c] ^= gmul(cf[(k - r + 4) % 4], t[k][c]);
        t = n;
      end
      s = t;
    end
    return s;
  endfunction

  task automatic send(input st_t c);
    bus.ct       = c;
    bus.in_valid = 1'b1;
    @(negedge clk);
    bus.in_valid = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    bus.ct = '0;
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b0;
    #12;
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    checks++;
    if (bus.in_ready !== 1'b1) begin
      failures++;
      $display("FAIL reset_in_ready got=%b want=1", bus.in_ready);
    end
    checks++;
    if (bus.out_valid !== 1'b0) begin
      failures++;
      $display("FAIL reset_out_valid got=%b want=0",
               bus.out_valid);
    end
    checks++;
    if (bus.pt !== '0) begin
      failures++;
      $display("FAIL reset_pt got=%h want=0", bus.pt);
    end
    checks++;
    if (bus.rk_idx !== 4'd10) begin
      failures++;
      $display("FAIL reset_rk_idx got=%0d want=10", bus.rk_idx);
    end
  endtask

  task automatic test_vec1();
    st_t c, e;
    int  seq_bad, lat_bad;
    set_key(128'h000102030405060708090a0b0c0d0e0f);
    c = from_hex(128'h69c4e0d86a7b0430d8cdb78070b4c55a);
    e = from_hex(128'h00112233445566778899aabbccddeeff);
    seq_bad = 0;
    lat_bad = 0;
    if (bus.rk_idx !== 4'd10) seq_bad++;
    send(c);
    for (int k = 0; k <= 10; k++) begin
      if (k > 0) @(negedge clk);
      if (bus.rk_idx !== ((k < 10) ? 4'(9 - k) : 4'd0))
        seq_bad++;
      if (bus.out_valid !== (k == 10)) lat_bad++;
    end
    checks++;
    if (seq_bad != 0) begin
      failures++;
      $display("FAIL v1_rk_seq got=%0d bad steps want=0",
               seq_bad);
    end
    checks++;
    if (lat_bad != 0) begin
      failures++;
      $display("FAIL v1_latency got=%0d bad cycles want=0",
               lat_bad);
    end
    checks++;
    if (bus.pt !== e) begin
      failures++;
      $display("FAIL v1_pt got=%h want=%h", bus.pt, e);
    end
    bus.out_ready = 1'b1;
    @(negedge clk);
    bus.out_ready = 1'b0;
    checks++;
    if (bus.out_valid !== 1'b0 || bus.in_ready !== 1'b1
        || bus.rk_idx !== 4'd10) begin
      failures++;
      $display("FAIL v1_release got=%b%b/%0d want=01/10",
               bus.out_valid, bus.in_ready, bus.rk_idx);
    end
  endtask

  task automatic test_vec2();
    st_t c, e, m1;
    set_key(128'h2b7e151628aed2a6abf7158809cf4f3c);
    c  = from_hex(128'h3925841d02dc09fbdc118597196a0b32);
    e  = from_hex(128'h3243f6a8885a308d313198a2e0370734);
    m1 = model(c, 1);
    send(c);
    @(negedge clk);
    checks++;
    if (bus.pt !== m1) begin
      failures++;
      $display("FAIL v2_round9 got=%h want=%h", bus.pt, m1);
    end
    repeat (9) @(negedge clk);
    checks++;
    if (bus.out_valid !== 1'b1 || bus.pt !== e) begin
      failures++;
      $display("FAIL v2_pt got=%h/%b want=%h/1",
               bus.pt, bus.out_valid, e);
    end
    bus.out_ready = 1'b1;
    @(negedge clk);
    bus.out_ready = 1'b0;
  endtask

  task automatic test_backpressure();
    st_t c1, c2, held, e2;
    int  bad;
    c1 = rand_st();
    send(c1);
    repeat (10) @(negedge clk);
    held = bus.pt;
    checks++;
    if (bus.out_valid !== 1'b1 || held !== model(c1, 10)) begin
      failures++;
      $display("FAIL bp_first_pt got=%h want=%h",
               held, model(c1, 10));
    end
    bad = 0;
    for (int i = 0; i < 20; i++) begin
      bus.ct = rand_st();
      bus.in_valid = 1'b1;
      @(negedge clk);
      if (bus.pt !== held || bus.in_ready !== 1'b0
          || bus.out_valid !== 1'b1 || bus.rk_idx !== 4'd0)
        bad++;
    end
    checks++;
    if (bad != 0) begin
      failures++;
      $display("FAIL bp_hold got=%0d bad cycles want=0", bad);
    end
    c2 = rand_st();
    e2 = model(c2, 10);
    bus.ct = c2;
    bus.out_ready = 1'b1;
    @(negedge clk);
    bus.out_ready = 1'b0;
    checks++;
    if (bus.in_ready !== 1'b1 || bus.out_valid !== 1'b0) begin
      failures++;
      $display("FAIL bp_release got=%b%b want=10",
               bus.in_ready, bus.out_valid);
    end
    @(negedge clk);
    bus.in_valid = 1'b0;
    checks++;
    if (bus.rk_idx !== 4'd9) begin
      failures++;
      $display("FAIL bp_accept got=%0d want=9", bus.rk_idx);
    end
    repeat (10) @(negedge clk);
    checks++;
    if (bus.out_valid !== 1'b1 || bus.pt !== e2) begin
      failures++;
      $display("FAIL bp_second_pt got=%h want=%h", bus.pt, e2);
    end
    bus.out_ready = 1'b1;
    @(negedge clk);
    bus.out_ready = 1'b0;
  endtask

  task automatic test_back_to_back();
    st_t expq [$];
    int  acc [$];
    int  nacc, nout, pt_bad, gap_bad;
    set_key({$urandom, $urandom, $urandom, $urandom});
    nacc = 0;
    nout = 0;
    pt_bad = 0;
    gap_bad = 0;
    bus.ct = rand_st();
    bus.in_valid  = 1'b1;
    bus.out_ready = 1'b1;
    for (int cyc = 0; cyc < 200 && nout < 8; cyc++) begin
      if (cyc > 0) @(negedge clk);
      if (bus.out_valid === 1'b1) begin
        if (expq.size() == 0) pt_bad++;
        else begin
          if (bus.pt !== expq[0]) pt_bad++;
          void'(expq.pop_front());
        end
        nout++;
      end
      if (bus.in_ready === 1'b1 && bus.in_valid) begin
        expq.push_back(model(bus.ct, 10));
        acc.push_back(cyc);
        nacc++;
      end else if (bus.in_ready !== 1'b1) begin
        bus.ct = rand_st();
        if (nacc >= 8) bus.in_valid = 1'b0;
      end
    end
    bus.in_valid = 1'b0;
    @(negedge clk);
    bus.out_ready = 1'b0;
    checks++;
    if (nout != 8) begin
      failures++;
      $display("FAIL b2b_count got=%0d want=8", nout);
    end
    checks++;
    if (pt_bad != 0) begin
      failures++;
      $display("FAIL b2b_pt got=%0d wrong want=0", pt_bad);
    end
    for (int i = 1; i < acc.size(); i++)
      if (acc[i] - acc[i-1] != 12) gap_bad++;
    checks++;
    if (gap_bad != 0 || acc.size() != 8) begin
      failures++;
      $display("FAIL b2b_spacing got=%0d bad/%0d acc want=0/8",
               gap_bad, acc.size());
    end
  endtask

  task automatic test_reset_mid();
    st_t c, e;
    set_key(128'h000102030405060708090a0b0c0d0e0f);
    send(rand_st());
    repeat (4) @(negedge clk);
    checks++;
    if (bus.rk_idx !== 4'd5) begin
      failures++;
      $display("FAIL rm_round got=%0d want=5", bus.rk_idx);
    end
    rst = 1'b1;
    #1;
    checks++;
    if (bus.out_valid !== 1'b0 || bus.pt !== '0
        || bus.in_ready !== 1'b1 || bus.rk_idx !== 4'd10) begin
      failures++;
      $display("FAIL rm_abort got=%b%b/%0d/%h want=01/10/0",
               bus.out_valid, bus.in_ready, bus.rk_idx, bus.pt);
    end
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    c = from_hex(128'h69c4e0d86a7b0430d8cdb78070b4c55a);
    e = from_hex(128'h00112233445566778899aabbccddeeff);
    send(c);
    repeat (10) @(negedge clk);
    checks++;
    if (bus.out_valid !== 1'b1 || bus.pt !== e) begin
      failures++;
      $display("FAIL rm_after got=%h want=%h", bus.pt, e);
    end
    bus.out_ready = 1'b1;
    @(negedge clk);
    bus.out_ready = 1'b0;
  endtask

  task automatic test_idle();
    st_t held;
    int  bad;
    held = bus.pt;
    bad = 0;
    for (int i = 0; i < 50; i++) begin
      bus.ct = rand_st();
      bus.in_valid = 1'b0;
      @(negedge clk);
      if (bus.pt !== held || bus.out_valid !== 1'b0
          || bus.in_ready !== 1'b1) bad++;
    end
    checks++;
    if (bad != 0) begin
      failures++;
      $display("FAIL idle_stable got=%0d bad cycles want=0", bad);
    end
  endtask

  initial begin
    build_sbox();
    test_reset();
    test_vec1();
    test_vec2();
    test_backpressure();
    test_back_to_back();
    test_reset_mid();
    test_idle();
    $display("TB_RESULT checks=%0d failures=%0d",
             checks, failures);
    $finish;
  end
endmodule
